// File: rtl/stack_drain_ctrl.sv
// Pops up to a requested number of items off a LIFO and streams them newest-first on valid/ready.
// Latency: start sampled at edge T, first pop in cycle T+1, first o_Valid in cycle T+2, o_Done at T+N+3.
// Backpressure: one-entry output register; no pop while it is full and not being drained by i_Ready.
module stack_drain_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 i_Clk,
    input  logic                 i_RstN,
    input  logic                 i_Start,
    input  logic [CNT_WIDTH-1:0] i_Count,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Underrun,
    output logic [CNT_WIDTH-1:0] o_Drained,
    input  logic                 i_StEmpty,
    input  logic [WIDTH-1:0]     i_StDat,
    output logic                 o_StPop,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Dat,
    input  logic                 i_Ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q,    state_d;
    logic [CNT_WIDTH-1:0]   remain_q,   remain_d;
    logic [CNT_WIDTH-1:0]   drained_q,  drained_d;
    logic                   underrun_q, underrun_d;
    logic                   valid_q,    valid_d;
    logic [WIDTH-1:0]       dat_q,      dat_d;

    logic                   out_free;
    logic                   out_hs;
    logic                   remain_nz;
    logic                   start_acc;
    logic                   pop;

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        out_free  = !valid_q || i_Ready;
        out_hs    = valid_q && i_Ready;
        remain_nz = (remain_q != '0);
        start_acc = (state_q == ST_IDLE) && i_Start;
        pop       = (state_q == ST_DRAIN) && remain_nz && !i_StEmpty && out_free;
    end

    // Next-state logic; an empty stack only ends the drain when the output register could have taken an item.
    always_comb begin
        state_d    = state_q;
        underrun_d = underrun_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d    = ST_DRAIN;
                    underrun_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!remain_nz) begin
                    state_d = ST_FLUSH;
                end else if (i_StEmpty && out_free) begin
                    state_d    = ST_FLUSH;
                    underrun_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (!valid_q || out_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register, remaining-item counter and delivered-item counter.
    always_comb begin
        valid_d   = valid_q;
        dat_d     = dat_q;
        remain_d  = remain_q;
        drained_d = drained_q;

        if (pop) begin
            valid_d  = 1'b1;
            dat_d    = i_StDat;
            remain_d = remain_q - 1'b1;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end

        if (start_acc) begin
            remain_d = i_Count;
        end

        // Bounded by the request, so the saturation guard never engages in normal use.
        if (start_acc) begin
            drained_d = '0;
        end else if (out_hs && (drained_q != '1)) begin
            drained_d = drained_q + 1'b1;
        end
    end

    // State register; reset discards any popped-but-undelivered item.
    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            drained_q  <= '0;
            underrun_q <= 1'b0;
            valid_q    <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            drained_q  <= drained_d;
            underrun_q <= underrun_d;
            valid_q    <= valid_d;
            dat_q      <= dat_d;
        end
    end

    // Status and stream outputs; the underrun flag is only exposed alongside o_Done.
    always_comb begin
        o_Busy     = (state_q != ST_IDLE);
        o_Done     = (state_q == ST_DONE);
        o_Underrun = (state_q == ST_DONE) && underrun_q;
        o_Drained  = drained_q;
        o_StPop    = pop;
        o_Valid    = valid_q;
        o_Dat      = dat_q;
    end

endmodule
